tone_sequencer: RTL

Parametrised multi-voice square-wave note sequencer for the DE1-SoC audio path. Plays a programmable table of up to SEQ_LEN notes, each holding one half-period per voice and a shared duration. The voices are summed with saturation into a signed sample. Samples are delivered to the Audio_Controller write port at a fixed sample rate. It replaces the free-running per-note tone generators in the audio demo top level and adds sequencing, rests, looping, saturation and overrun accounting.

---
 rtl/tone_seq_pkg.sv | 15 +
 rtl/tone_voice.sv | 70 +++++++
 rtl/tone_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tone_seq_pkg.sv
// Shared state encoding, sample width and saturating clamp for tone_sequencer.
package tone_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2} state_t;

  localparam int SAMPLE_W = 32;
  localparam int ACC_W    = 64;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 64'sd1;

  function automatic logic signed [SAMPLE_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return 32'sh7FFF_FFFF;
    else if (v < SAT_MIN) return 32'sh8000_0000;
    else                  return v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: phase counter, level toggle, rest detect, signed contribution.
// TONE_SEQ_DECAY_EN adds an amplitude halving every DECAY_PERIOD PLAY cycles.
module tone_voice
  import tone_seq_pkg::*;
#(
  parameter int          DIV_W = 21,
  parameter logic [31:0] AMP   = 32'd10000000
`ifdef TONE_SEQ_DECAY_EN
  , parameter int        DECAY_PERIOD = 1048576
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_load,
  input  logic                       i_play,
  input  logic [DIV_W-1:0]           i_half,
  output logic signed [SAMPLE_W-1:0] o_contrib
);
  logic [DIV_W-1:0]           r_half, r_phase;
  logic                       r_level;
  logic signed [SAMPLE_W-1:0] w_amp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half  <= '0;
      r_phase <= '0;
      r_level <= 1'b0;
    end else if (i_load) begin
      r_half  <= i_half;
      r_phase <= '0;
      r_level <= 1'b1;
    end else if (i_play && r_half != '0) begin
      if (r_phase == r_half - DIV_W'(1)) begin
        r_phase <= '0;
        r_level <= ~r_level;
      end else begin
        r_phase <= r_phase + DIV_W'(1);
      end
    end
  end

`ifdef TONE_SEQ_DECAY_EN
  localparam int DC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [DC_W-1:0]            r_dcnt;
  logic signed [SAMPLE_W-1:0] r_amp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dcnt <= '0;
      r_amp  <= '0;
    end else if (i_load) begin
      r_dcnt <= '0;
      r_amp  <= signed'(AMP);
    end else if (i_play) begin
      if (r_dcnt == DC_W'(DECAY_PERIOD - 1)) begin
        r_dcnt <= '0;
        r_amp  <= r_amp >>> 1;
      end else begin
        r_dcnt <= r_dcnt + DC_W'(1);
      end
    end
  end
  assign w_amp = r_amp;
`else
  assign w_amp = signed'(AMP);
`endif

  // A resting voice (H=0) and every non-PLAY state contribute silence.
  assign o_contrib = (!i_play || r_half == '0) ? '0 : (r_level ? w_amp : -w_amp);
endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice square-wave note sequencer feeding the Audio_Controller write port.
// Optional per-note amplitude decay is enabled by defining TONE_SEQ_DECAY_EN.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int          N_VOICES     = 2,
  parameter int          SEQ_LEN      = 8,
  parameter int          DIV_W        = 21,
  parameter int          DUR_W        = 26,
  parameter logic [31:0] AMP          = 32'd10000000,
  parameter int          SAMPLE_DIV   = 1042,
  parameter int          DECAY_PERIOD = 1048576,
  localparam int         IDX_W        = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int         VW           = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic                prog_we,
  input  logic [IDX_W-1:0]    prog_addr,
  input  logic [VW-1:0]       prog_voice,
  input  logic [DIV_W-1:0]    prog_half,
  input  logic                prog_dur_we,
  input  logic [DUR_W-1:0]    prog_dur,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                busy,
  output logic [IDX_W-1:0]    note_idx,
  output logic                done,
  output logic [15:0]         overruns
);
  localparam int SUM_W = SAMPLE_W + $clog2(N_VOICES) + 1;
  localparam int SD_W  = $clog2(SAMPLE_DIV + 1);

  // A non-positive decay period is a configuration error; flag it in the hierarchy.
  if (DECAY_PERIOD < 1) begin : g_bad_decay_period
  end

  state_t                     r_state;
  logic [IDX_W-1:0]           r_idx;
  logic [DUR_W-1:0]           r_dur;
  logic                       r_busy, r_done, r_wr;
  logic [15:0]                r_ovr;
  logic signed [SAMPLE_W-1:0] r_sample;
  logic [SD_W-1:0]            r_div;
  logic [DIV_W-1:0]           r_half_tbl [SEQ_LEN][N_VOICES];
  logic [DUR_W-1:0]           r_dur_tbl  [SEQ_LEN];

  logic signed [SAMPLE_W-1:0] w_contrib [N_VOICES];
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_acc;
  logic [DUR_W-1:0]           w_dur_ld;
  logic                       w_tick, w_load, w_play;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < SEQ_LEN; a++) begin
        r_dur_tbl[a] <= '0;
        for (int v = 0; v < N_VOICES; v++) r_half_tbl[a][v] <= '0;
      end
    end else if (prog_we && r_state == IDLE) begin
      r_half_tbl[prog_addr][prog_voice] <= prog_half;
      if (prog_dur_we) r_dur_tbl[prog_addr] <= prog_dur;
    end
  end

  assign w_dur_ld = (r_dur_tbl[r_idx] == '0) ? DUR_W'(1) : r_dur_tbl[r_idx];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dur   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
          LOAD: begin
            r_dur   <= w_dur_ld;
            r_state <= PLAY;
          end
          PLAY: if (r_dur == DUR_W'(1)) begin
            if (r_idx != IDX_W'(SEQ_LEN - 1)) begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= LOAD;
            end else if (loop) begin
              r_idx   <= '0;
              r_state <= LOAD;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_dur <= r_dur - DUR_W'(1);
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_load = (r_state == LOAD);
  assign w_play = (r_state == PLAY);

  for (genvar g = 0; g < N_VOICES; g++) begin : g_voice
    tone_voice #(
      .DIV_W(DIV_W),
      .AMP(AMP)
`ifdef TONE_SEQ_DECAY_EN
      , .DECAY_PERIOD(DECAY_PERIOD)
`endif
    ) u_voice (
      .clk(CLOCK_50), .rst(reset), .i_load(w_load), .i_play(w_play),
      .i_half(r_half_tbl[r_idx][g]), .o_contrib(w_contrib[g])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int v = 0; v < N_VOICES; v++)
      w_sum = w_sum + {{(SUM_W-SAMPLE_W){w_contrib[v][SAMPLE_W-1]}}, w_contrib[v]};
  end
  assign w_acc  = {{(ACC_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
  assign w_tick = (r_div == SD_W'(SAMPLE_DIV - 1));

  // Divider and sample register run in every state so the codec rate never stalls.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_wr     <= 1'b0;
      r_ovr    <= '0;
      r_sample <= '0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + SD_W'(1);
      r_wr     <= w_tick & audio_out_allowed;
      r_sample <= sat_clamp(w_acc);
      if (w_tick && !audio_out_allowed && r_ovr != 16'hFFFF) r_ovr <= r_ovr + 16'd1;
    end
  end

  assign write_audio_out = r_wr;
  assign sample_out      = r_sample;
  assign busy            = r_busy;
  assign note_idx        = r_idx;
  assign done            = r_done;
  assign overruns        = r_ovr;
endmodule
